// File: rtl/dtfm_serializer.sv
// DTFM serial telemetry source: 20-word strings on dCLK/dFM/dDAT, payload prefetched from a word store.
// Define DTFM_SER_PATTERN_EN to add patSel, which substitutes a counter pattern for store payload.
module dtfm_serializer #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
`ifdef DTFM_SER_PATTERN_EN
    input  logic        patSel,
`endif
    output logic        dCLK,
    output logic        dFM,
    output logic        dDAT,
    output logic        wReq,
    output logic [4:0]  wAddr,
    input  logic [15:0] wData
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam int            RD_LAT   = 2;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, stateNx;

    logic [DW-1:0]   divCnt;
    logic [3:0]      bitCnt;
    logic [4:0]      wordCnt;
    logic [5:0]      strNum;
    logic [8:0]      frmNum;
    logic [15:0]     shReg;
    logic [15:0]     nbuf;
    logic [RD_LAT:0] vldPipe;

    logic        start, fall, load, shift;
    logic [4:0]  wordNx;
    logic [5:0]  strNx;
    logic [8:0]  frmNx;
    logic        isHdr, patOn, reqOn;
    logic [4:0]  reqAddr;
    logic [15:0] wordLd;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNx;
    end

    always_comb begin
        stateNx = state;
        case (state)
            IDLE:    if (en)  stateNx = RUN;
            RUN:     if (!en) stateNx = IDLE;
            default: stateNx = IDLE;
        endcase
    end

    always_comb begin
        start = 1'b0;
        fall  = 1'b0;
        case (state)
            IDLE:    start = en;
            RUN:     fall  = en && dCLK && (divCnt == DIV_LAST);
            default: ;
        endcase
    end

    assign load  = start || (fall && (bitCnt == 4'd0));
    assign shift = fall && (bitCnt != 4'd0);

    // ---------------- next-word composition ----------------
    // Counters advance at the word boundary, so headers carry the post-increment values.
    always_comb begin
        wordNx = 5'd0;
        strNx  = 6'd0;
        frmNx  = 9'd0;
        if (!start) begin
            wordNx = (wordCnt == 5'd19) ? 5'd0 : wordCnt + 5'd1;
            strNx  = strNum;
            frmNx  = frmNum;
            if (wordCnt == 5'd9 || wordCnt == 5'd19) begin
                strNx = strNum + 6'd1;
                if (strNum == 6'd63) frmNx = frmNum + 9'd1;
            end
        end
    end

`ifdef DTFM_SER_PATTERN_EN
    assign patOn = patSel;
`else
    assign patOn = 1'b0;
`endif

    assign isHdr = (wordNx == 5'd0) || (wordNx == 5'd10);

    always_comb begin
        if (isHdr)      wordLd = {frmNx, strNx, wordNx == 5'd0};
        else if (patOn) wordLd = {strNx, wordNx, 5'b10101};
        else            wordLd = nbuf;
    end

    // Word 9 prefetches 11 (10 is a header); word 10 and 19 loads request nothing.
    always_comb begin
        reqAddr = (wordNx == 5'd9) ? 5'd11 : wordNx + 5'd1;
        reqOn   = load && !patOn && (wordNx != 5'd10) && (wordNx != 5'd19);
    end

    assign wReq = vldPipe[0];

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt  <= '0;
            dCLK    <= 1'b0;
            dFM     <= 1'b0;
            dDAT    <= 1'b0;
            wAddr   <= 5'd0;
            vldPipe <= '0;
            bitCnt  <= 4'd15;
            wordCnt <= 5'd0;
            strNum  <= 6'd0;
            frmNum  <= 9'd0;
            shReg   <= 16'd0;
            nbuf    <= 16'd0;
        end else if (!en) begin
            divCnt  <= '0;
            dCLK    <= 1'b0;
            dFM     <= 1'b0;
            dDAT    <= 1'b0;
            wAddr   <= 5'd0;
            vldPipe <= '0;
            bitCnt  <= 4'd15;
            wordCnt <= 5'd0;
            strNum  <= 6'd0;
            frmNum  <= 9'd0;
            shReg   <= 16'd0;
            nbuf    <= 16'd0;
        end else begin
            if (start) begin
                divCnt <= '0;
                dCLK   <= 1'b0;
            end else if (divCnt == DIV_LAST) begin
                divCnt <= '0;
                dCLK   <= ~dCLK;
            end else begin
                divCnt <= divCnt + DW'(1);
            end

            vldPipe <= {vldPipe[RD_LAT-1:0], reqOn};
            if (reqOn)           wAddr <= reqAddr;
            if (vldPipe[RD_LAT]) nbuf  <= wData;

            if (load) begin
                shReg   <= wordLd;
                dDAT    <= wordLd[15];
                dFM     <= (wordNx == 5'd0) && (strNx == 6'd0);
                bitCnt  <= 4'd15;
                wordCnt <= wordNx;
                strNum  <= strNx;
                frmNum  <= frmNx;
            end else if (shift) begin
                shReg  <= {shReg[14:0], 1'b0};
                dDAT   <= shReg[14];
                dFM    <= 1'b0;
                bitCnt <= bitCnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_dtfm_serializer.sv
// Bench for dtfm_serializer: table + scoreboard of serialized words, fetch address log, timing monitors.
module tb_dtfm_serializer;
    localparam int CDIV = 2;
    localparam int BITT = 2 * CDIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        dCLK, dFM, dDAT, wReq;
    logic [4:0]  wAddr;
    logic [15:0] wData = 16'hDEAD;
    logic [15:0] st_d1 = 16'hDEAD;
`ifdef DTFM_SER_PATTERN_EN
    logic        patSel = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    bit dead = 1'b0;

    always #5 clk = ~clk;

    dtfm_serializer #(.CLK_DIV(CDIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
`ifdef DTFM_SER_PATTERN_EN
        .patSel(patSel),
`endif
        .dCLK  (dCLK),
        .dFM   (dFM),
        .dDAT  (dDAT),
        .wReq  (wReq),
        .wAddr (wAddr),
        .wData (wData)
    );

    function automatic logic [15:0] store_val(logic [4:0] a);
        return (a == 5'd1) ? 16'h44D4 : {3'b101, a, 3'b000, a};
    endfunction

    // word store: data valid exactly 2 clk after the request cycle, junk otherwise
    always @(posedge clk) begin
        st_d1 <= wReq ? store_val(wAddr) : 16'hDEAD;
        wData <= st_d1;
    end

    int cyc = 0;
    int rise_t = 0;
    int dclk_per = 0;
    int fm_run = 0;
    logic dclk_prev = 1'b0;
    logic fm_prev = 1'b0;
    int fm_rise_q[$];
    int fm_len_q[$];
    int addr_q[$];

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        dclk_prev <= dCLK;
        fm_prev   <= dFM;
        if (dCLK && !dclk_prev) begin
            rise_t   <= cyc;
            dclk_per <= cyc - rise_t;
        end
        if (dFM && !fm_prev) fm_rise_q.push_back(cyc);
        fm_run <= dFM ? fm_run + 1 : 0;
        if (!dFM && fm_prev) fm_len_q.push_back(fm_run);
        if (wReq) addr_q.push_back(int'(wAddr));
    end

    typedef struct {
        int          k;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[8];

    function automatic logic [15:0] model_word(int k);
        int w, s;
        logic [5:0] sn;
        logic [8:0] fn;
        w  = k % 20;
        s  = 2 * (k / 20) + ((w >= 10) ? 1 : 0);
        sn = 6'(s % 64);
        fn = 9'((s / 64) % 512);
        if (w == 0)  return {fn, sn, 1'b1};
        if (w == 10) return {fn, sn, 1'b0};
        return store_val(5'(w));
    endfunction

    function automatic logic [15:0] exp_for(int k);
        for (int i = 0; i < 8; i++) if (vt[i].k == k) return vt[i].exp;
        return model_word(k);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic get_bit(output logic b, output logic f);
        logic prev;
        int n;
        b = 1'b0;
        f = 1'b0;
        if (dead) return;
        n = 0;
        prev = dCLK;
        @(negedge clk);
        while (!(dCLK && !prev)) begin
            if (n > 4 * BITT) begin
                dead = 1'b1;
                checks++;
                errors++;
                $display("FAIL dclk_timeout: no dCLK rise within %0d clk", n);
                return;
            end
            prev = dCLK;
            @(negedge clk);
            n++;
        end
        b = dDAT;
        f = dFM;
    endtask

    task automatic get_word(output logic [15:0] w, output logic fm0);
        logic b, f;
        w = 16'd0;
        fm0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            get_bit(b, f);
            w = {w[14:0], b};
            if (i == 0) fm0 = f;
        end
    endtask

    int seq[18] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13, 14, 15, 16, 17, 18, 19};

    initial begin
        logic [15:0] exp_q[$];
        logic [15:0] w, e, last;
        logic f, b;
        int base_a, base_f, base_l;

        vt[0] = '{0,  16'h0001};
        vt[1] = '{1,  16'h44D4};
        vt[2] = '{2,  16'hA202};
        vt[3] = '{9,  16'hA909};
        vt[4] = '{10, 16'h0002};
        vt[5] = '{11, 16'hAB0B};
        vt[6] = '{19, 16'hB313};
        vt[7] = '{20, 16'h0005};
        last = 16'd0;

        // reset and idle
        repeat (3) @(negedge clk);
        chk("reset_out", {dCLK, dFM, dDAT, wReq, wAddr}, 9'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_out", {dCLK, dFM, dDAT, wReq, wAddr}, 9'd0);

        // one full frame plus the next frame's first header
        base_a = addr_q.size();
        base_f = fm_rise_q.size();
        base_l = fm_len_q.size();
        for (int k = 0; k <= 640; k++) exp_q.push_back(exp_for(k));
        en = 1'b1;
        for (int k = 0; k <= 640; k++) begin
            get_word(w, f);
            e = exp_q.pop_front();
            chk($sformatf("word%0d", k), w, e);
            chk($sformatf("fm%0d", k), f, (k % 640) == 0);
            if (k == 640) last = w;
        end
        chk("frame1_hdr", last, 16'h0081);
        chk("dclk_period", dclk_per, BITT);
        chk("n_fm_pulses", fm_rise_q.size() - base_f, 2);
        if (fm_rise_q.size() - base_f >= 2)
            chk("frame_spacing", fm_rise_q[base_f+1] - fm_rise_q[base_f], 10240 * BITT);
        chk("n_fm_len", (fm_len_q.size() > base_l) ? 1 : 0, 1);
        if (fm_len_q.size() > base_l) chk("fm_len", fm_len_q[base_l], BITT);
        chk("n_req", addr_q.size() - base_a, 577);
        for (int i = 0; i < 577 && base_a + i < addr_q.size(); i++)
            chk($sformatf("waddr%0d", i), addr_q[base_a+i], seq[i%18]);

        en = 1'b0;
        @(negedge clk);
        chk("en_off_out", {dCLK, dFM, dDAT, wReq, wAddr}, 9'd0);

        // drop en in the middle of word 5, then restart from frame 0
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_for(k));
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            get_word(w, f);
            e = exp_q.pop_front();
            chk($sformatf("c_word%0d", k), w, e);
        end
        repeat (6) get_bit(b, f);
        en = 1'b0;
        @(negedge clk);
        chk("drop_en_out", {dCLK, dFM, dDAT, wReq, wAddr}, 9'd0);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h44D4);
        en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            get_word(w, f);
            e = exp_q.pop_front();
            chk($sformatf("restart_word%0d", k), w, e);
            chk($sformatf("restart_fm%0d", k), f, k == 0);
        end

        // asynchronous reset mid-bit while dCLK is high
        get_bit(b, f);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {dCLK, dFM, dDAT, wReq, wAddr}, 9'd0);
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h44D4);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            get_word(w, f);
            e = exp_q.pop_front();
            chk($sformatf("post_rst_word%0d", k), w, e);
        end

`ifdef DTFM_SER_PATTERN_EN
        en = 1'b0;
        @(negedge clk);
        patSel = 1'b1;
        base_a = addr_q.size();
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0035);
        exp_q.push_back(16'h0055);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            get_word(w, f);
            e = exp_q.pop_front();
            chk($sformatf("pat_word%0d", k), w, e);
        end
        chk("pat_no_req", addr_q.size() - base_a, 0);
        patSel = 1'b0;
`endif

        en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
